// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, decoder
// opcodes that produce control transfers, and default reset address.
package instruction_fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          PC_W_DEFAULT     = 32;
    localparam int          OFFSET_W_DEFAULT = 8;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Opcodes whose offset field drives the next-PC target.
    localparam logic [7:0] OP_J   = 8'h06;
    localparam logic [7:0] OP_BEQ = 8'h07;
    localparam logic [7:0] OP_BNE = 8'h0C;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

    // True for any opcode that may redirect the program counter.
    function automatic logic is_ctrl_op(input logic [7:0] opcode);
        logic hit;
        case (opcode)
            OP_J, OP_BEQ, OP_BNE: hit = 1'b1;
            default:              hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory handshake, data-memory stall, decoder
// redirect inputs and the issued instruction toward the decoder.
interface instruction_fetch_unit_if
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int OFFSET_W = OFFSET_W_DEFAULT
);
    logic                imem_read;
    logic [PC_W-1:0]     imem_addr;
    logic [INSTR_W-1:0]  imem_readdata;
    logic                imem_busywait;
    logic                dmem_busywait;
    logic                jump;
    logic                branch_taken;
    logic [OFFSET_W-1:0] offset_8bit;
    logic [INSTR_W-1:0]  instruction;
    logic                instr_valid;
    logic [PC_W-1:0]     pc;

    modport master (
        output imem_read, imem_addr, instruction, instr_valid, pc,
        input  imem_readdata, imem_busywait, dmem_busywait,
               jump, branch_taken, offset_8bit
    );

    modport slave (
        input  imem_read, imem_addr, instruction, instr_valid, pc,
        output imem_readdata, imem_busywait, dmem_busywait,
               jump, branch_taken, offset_8bit
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_next_adder.sv
// Next-PC computation: sequential PC+4 or PC+4 plus a sign-extended word
// offset, both wrapping modulo 2^PC_W.
module pc_next_adder
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int OFFSET_W = OFFSET_W_DEFAULT
) (
    input  logic [PC_W-1:0]     pc_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic                take_i,
    output logic [PC_W-1:0]     next_pc_o
);
    logic [PC_W-1:0] pc_seq_s;
    logic [PC_W-1:0] offset_bytes_s;
    logic [PC_W-1:0] target_s;

    // Word offset becomes a byte offset: sign-extend, then append two zero bits.
    assign offset_bytes_s = {{(PC_W-OFFSET_W-2){offset_i[OFFSET_W-1]}}, offset_i, 2'b00};

    // Sequential and target addresses; carries out of PC_W are dropped.
    always_comb begin
        pc_seq_s = pc_i + PC_W'(4);
        target_s = pc_seq_s + offset_bytes_s;
        if (take_i) begin
            next_pc_o = target_s;
        end else begin
            next_pc_o = pc_seq_s;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, FETCH/WAIT/ISSUE handshake FSM with
// instruction memory, and the latched instruction presented to the decoder.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              OFFSET_W = OFFSET_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    instruction_fetch_unit_if.master bus
);
    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_valid_q;
    logic               imem_read_q;
    logic               take_s;

    assign take_s = bus.jump | bus.branch_taken;

    pc_next_adder #(
        .PC_W     (PC_W),
        .OFFSET_W (OFFSET_W)
    ) u_pc_next_adder (
        .pc_i      (pc_q),
        .offset_i  (bus.offset_8bit),
        .take_i    (take_s),
        .next_pc_o (pc_d)
    );

    // Fetch FSM with registered outputs. Out of reset FETCH spends one cycle
    // raising IMEM_READ before any readdata is eligible for latching.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= {INSTR_W{1'b0}};
            instr_valid_q <= 1'b0;
            imem_read_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!imem_read_q) begin
                        imem_read_q <= 1'b1;
                    end else if (!bus.imem_busywait) begin
                        instr_q       <= bus.imem_readdata;
                        instr_valid_q <= 1'b1;
                        imem_read_q   <= 1'b0;
                        state_q       <= ST_ISSUE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.imem_busywait) begin
                        instr_q       <= bus.imem_readdata;
                        instr_valid_q <= 1'b1;
                        imem_read_q   <= 1'b0;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Redirect inputs only matter on the edge that retires the issue.
                    if (!bus.dmem_busywait) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        imem_read_q   <= 1'b1;
                        state_q       <= ST_FETCH;
                    end
                end
                default: begin
                    state_q       <= ST_FETCH;
                    instr_valid_q <= 1'b0;
                    imem_read_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_read   = imem_read_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = instr_valid_q;
endmodule
